// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and coordinate widths for the VGA path.
package vga_pkg;
  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_PIX_PER_WORD = 2;
endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus registered active/sync decodes,
// decoded from the next-state count so they line up with cnt.
module vga_axis_counter #(
  parameter int W      = 11,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] reset_cnt,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync_active
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT     = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] nxt;
  logic [W-1:0] ld;

  assign wrap = ce && (cnt == LAST);

  always_comb begin
    nxt = cnt;
    if (ce) nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    ld = reset ? reset_cnt : nxt;
  end

  always_ff @(posedge clk) begin
    cnt         <= ld;
    active      <= (ld < ACT);
    sync_active <= (ld >= SYNC_LO) && (ld < SYNC_HI);
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing: syncs, display enable, coordinates and the fetch-address
// strobes for the downstream frame-buffer address controller.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter int PIX_PER_WORD = VGA_PIX_PER_WORD,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_ce,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           next_addr,
  output logic           reset_addr,
  output logic           frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [X_W-1:0] WORD_LAST = X_W'(PIX_PER_WORD - 1);
  localparam logic [Y_W-1:0] V_LAST_ACT = Y_W'(V_ACTIVE - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate width");
  end
  if (!(PIX_PER_WORD == 1 || PIX_PER_WORD == 2 || PIX_PER_WORD == 4) ||
      (H_ACTIVE % PIX_PER_WORD) != 0) begin : g_bad_ppw
    $error("vga_timing_gen: PIX_PER_WORD must be 1/2/4 and divide H_ACTIVE");
  end

  logic h_wrap, h_act, h_sync;
  logic v_wrap, v_act, v_sync;
  logic frame_ra;
  logic rst_seen;

  vga_axis_counter #(.W(X_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .reset(reset), .ce(pix_ce), .reset_cnt('0),
    .cnt(x), .wrap(h_wrap), .active(h_act), .sync_active(h_sync)
  );

  vga_axis_counter #(.W(Y_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .reset(reset), .ce(h_wrap), .reset_cnt(Y_W'(V_ACTIVE)),
    .cnt(y), .wrap(v_wrap), .active(v_act), .sync_active(v_sync)
  );

  assign de    = h_act & v_act;
  assign hsync = h_sync ? HSYNC_POL : ~HSYNC_POL;
  assign vsync = v_sync ? VSYNC_POL : ~VSYNC_POL;

  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr   <= 1'b0;
      frame_ra    <= 1'b0;
      frame_start <= 1'b0;
      rst_seen    <= 1'b1;
    end else begin
      // current x/de describe the pixel leaving display on this pix_ce edge
      next_addr   <= pix_ce && de && ((x & WORD_LAST) == WORD_LAST);
      frame_ra    <= h_wrap && (y == V_LAST_ACT);
      frame_start <= v_wrap;
      rst_seen    <= 1'b0;
    end
  end

  // post-reset rewind shows up in the first cycle reset is low, before any edge
  assign reset_addr = (rst_seen && !reset) || frame_ra;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-timing instance checked per cycle against a pixel
// model, default instance checked for reset state and line/blanking counts.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s, pix_ce_s, reset_b, pix_ce_b;
  logic        hsync_s, vsync_s, de_s, next_addr_s, reset_addr_s, frame_start_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic        hsync_b, vsync_b, de_b, next_addr_b, reset_addr_b, frame_start_b;
  logic [10:0] x_b;
  logic [9:0]  y_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ex, ey, n_na, n_ra, n_fs;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_PER_WORD(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset(reset_s), .pix_ce(pix_ce_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .x(x_s), .y(y_s),
    .next_addr(next_addr_s), .reset_addr(reset_addr_s), .frame_start(frame_start_s)
  );

  vga_timing_gen dut_b (
    .clk(clk), .reset(reset_b), .pix_ce(pix_ce_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .next_addr(next_addr_b), .reset_addr(reset_addr_b), .frame_start(frame_start_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run npix pixel ticks on the small instance, pix_ce high one clk in 'period'.
  task automatic run_px(input int period, input int npix);
    int k, done, px, py;
    bit ce;
    k = 0; done = 0;
    n_na = 0; n_ra = 0; n_fs = 0;
    while (done < npix) begin
      ce = (k % period) == 0;
      pix_ce_s = ce;
      k++;
      px = ex; py = ey;
      tick;
      if (ce) begin
        done++;
        ex++;
        if (ex == 14) begin ex = 0; ey = (ey + 1) % 7; end
      end
      chk("x", x_s, ex);
      chk("y", y_s, ey);
      chk("de", de_s, (ex < 8 && ey < 4));
      chk("hsync", hsync_s, !(ex >= 10 && ex < 12));
      chk("vsync", vsync_s, !(ey == 5));
      chk("next_addr", next_addr_s, ce && px < 8 && py < 4 && (px % 2) == 1);
      chk("reset_addr", reset_addr_s, ce && ex == 0 && ey == 4);
      chk("frame_start", frame_start_s, ce && ex == 0 && ey == 0);
      n_na += int'(next_addr_s);
      n_ra += int'(reset_addr_s);
      n_fs += int'(frame_start_s);
    end
  endtask

  initial begin
    int t, hs_low;
    reset_s = 1'b1; pix_ce_s = 1'b0;
    reset_b = 1'b1; pix_ce_b = 1'b1;
    repeat (3) tick;

    chk("rst_x", x_s, 0);
    chk("rst_y", y_s, 4);
    chk("rst_de", de_s, 0);
    chk("rst_hsync", hsync_s, 1);
    chk("rst_vsync", vsync_s, 1);
    chk("rst_next_addr", next_addr_s, 0);
    chk("rst_reset_addr", reset_addr_s, 0);
    chk("rst_frame_start", frame_start_s, 0);

    // release with pix_ce low: rewind pulse still fires, counters stay frozen
    reset_s = 1'b0;
    #1;
    chk("rel_reset_addr", reset_addr_s, 1);
    chk("rel_x", x_s, 0);
    chk("rel_y", y_s, 4);
    tick;
    chk("rel_reset_addr_once", reset_addr_s, 0);
    chk("frozen_x", x_s, 0);
    chk("frozen_y", y_s, 4);

    ex = 0; ey = 4;
    run_px(1, 42);
    chk("blank_na", n_na, 0);
    chk("blank_ra", n_ra, 0);
    chk("first_fs", n_fs, 1);
    chk("first_fs_de", de_s, 1);

    run_px(1, 98);
    chk("frame_na", n_na, 16);
    chk("frame_ra", n_ra, 1);
    chk("frame_fs", n_fs, 1);

    run_px(4, 98);
    chk("ce4_na", n_na, 16);
    chk("ce4_ra", n_ra, 1);
    chk("ce4_fs", n_fs, 1);

    // mid-frame reset at (5,2)
    run_px(1, 33);
    reset_s = 1'b1; pix_ce_s = 1'b1;
    repeat (3) begin
      tick;
      chk("mid_rst_na", next_addr_s, 0);
      chk("mid_rst_ra", reset_addr_s, 0);
      chk("mid_rst_x", x_s, 0);
      chk("mid_rst_y", y_s, 4);
    end
    reset_s = 1'b0;
    #1;
    chk("mid_rel_ra", reset_addr_s, 1);
    ex = 0; ey = 4;
    run_px(1, 42);
    chk("mid_blank_na", n_na, 0);
    chk("mid_blank_ra", n_ra, 0);
    chk("mid_fs", n_fs, 1);
    run_px(1, 14);
    chk("mid_line0_na", n_na, 4);

    // default 640x480 instance
    reset_b = 1'b0;
    #1;
    chk("b_rel_ra", reset_addr_b, 1);
    chk("b_x", x_b, 0);
    chk("b_y", y_b, 480);
    chk("b_de", de_b, 0);
    chk("b_hsync", hsync_b, 1);
    chk("b_vsync", vsync_b, 1);
    chk("b_fs", frame_start_b, 0);
    t = 0; n_na = 0; n_ra = 0;
    while (!frame_start_b && t < 40000) begin
      tick;
      t++;
      n_na += int'(next_addr_b);
      n_ra += int'(reset_addr_b);
    end
    chk("b_blank_ticks", t, 36000);
    chk("b_blank_na", n_na, 0);
    chk("b_blank_ra", n_ra, 0);
    chk("b_fs_x", x_b, 0);
    chk("b_fs_y", y_b, 0);
    chk("b_fs_de", de_b, 1);
    n_na = 0; hs_low = 0;
    repeat (800) begin
      tick;
      n_na += int'(next_addr_b);
      hs_low += int'(!hsync_b);
    end
    chk("b_line_na", n_na, 320);
    chk("b_line_hs_low", hs_low, 96);
    chk("b_line_end_x", x_b, 0);
    chk("b_line_end_y", y_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
